ram2_arbiter: RTL

RAM2_ARBITER -- requirements
Module: ram2_arbiter

---
 rtl/ram2_arbiter_pkg.sv | 27 ++
 rtl/ram2_arbiter_if.sv | 33 +++
 rtl/ram2_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ram2_arbiter_pkg.sv
// Shared CPU definitions for the two-port SRAM arbiter: FSM state and bus
// owner encodings, bus widths and the SRAM address mapping.
package ram2_arbiter_pkg;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned RAM_ADDR_W = 18;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

   // CPU word addresses land in the low 64K words of the SRAM.
   function automatic logic [RAM_ADDR_W-1:0] ram_addr(input logic [ADDR_W-1:0] a);
      return {2'b00, a};
   endfunction

endpackage

// File: rtl/ram2_arbiter_if.sv
// CPU-side port bundle of the SRAM arbiter: instruction-fetch and MEM-stage
// request/acknowledge channels plus the IF stall indication.
interface ram2_arbiter_if;
   import ram2_arbiter_pkg::*;

   // A requester raises *_req_i with stable address/data and holds all of them
   // until its *_ack_o pulse has been seen; the ack is a single-cycle pulse and
   // the matching *_rdata_o stays valid until that port's next read completes.
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_ack_o;
   logic [DATA_W-1:0] if_rdata_o;

   logic              mem_req_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [DATA_W-1:0] mem_wdata_i;
   logic              mem_ack_o;
   logic [DATA_W-1:0] mem_rdata_o;

   logic              ram2_conflict_o;

   modport master (
      output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
      input  if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o, ram2_conflict_o
   );

   modport slave (
      input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
      output if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o, ram2_conflict_o
   );

endinterface

// File: rtl/ram2_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one asynchronous
// SRAM; MEM wins ties, writes use a setup/pulse/hold strobe sequence.
module ram2_arbiter
   import ram2_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   ram2_arbiter_if.slave         cpu,
   output logic [RAM_ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0]     ram_data_o,
   input  logic [DATA_W-1:0]     ram_data_i,
   output logic                  ram_data_oe_o,
   output logic                  ram_ce_n_o,
   output logic                  ram_oe_n_o,
   output logic                  ram_we_n_o,
   output arb_state_e            dbg_state_o
);

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]     ram_data_q, ram_data_d;
   logic                  data_oe_q, data_oe_d;
   logic                  ce_n_q, ce_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  we_n_q, we_n_d;
   logic                  if_ack_q, if_ack_d;
   logic                  mem_ack_q, mem_ack_d;
   logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;

   // Strobes are computed for the state being entered, so every SRAM pin
   // leaves a flop and the bus is quiet whenever the next state is IDLE.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;
      data_oe_d   = 1'b0;
      ce_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      we_n_d      = 1'b1;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            // A port still showing its ack is the request just served.
            if (cpu.mem_req_i && !mem_ack_q) begin
               owner_d    = OWN_MEM;
               ram_addr_d = ram_addr(cpu.mem_addr_i);
               ce_n_d     = 1'b0;
               if (cpu.mem_we_i) begin
                  state_d    = ST_WR_SETUP;
                  ram_data_d = cpu.mem_wdata_i;
                  data_oe_d  = 1'b1;
               end else begin
                  state_d = ST_READ;
                  oe_n_d  = 1'b0;
               end
            end else if (cpu.if_req_i && !if_ack_q) begin
               owner_d    = OWN_IF;
               ram_addr_d = ram_addr(cpu.if_addr_i);
               state_d    = ST_READ;
               ce_n_d     = 1'b0;
               oe_n_d     = 1'b0;
            end
         end
         ST_READ: begin
            state_d = ST_IDLE;
            if (owner_q == OWN_MEM) begin
               mem_rdata_d = ram_data_i;
               mem_ack_d   = 1'b1;
            end else begin
               if_rdata_d = ram_data_i;
               if_ack_d   = 1'b1;
            end
         end
         ST_WR_SETUP: begin
            state_d   = ST_WR_PULSE;
            ce_n_d    = 1'b0;
            data_oe_d = 1'b1;
            we_n_d    = 1'b0;
         end
         ST_WR_PULSE: begin
            state_d   = ST_WR_HOLD;
            ce_n_d    = 1'b0;
            data_oe_d = 1'b1;
         end
         ST_WR_HOLD: begin
            state_d   = ST_IDLE;
            mem_ack_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         data_oe_q   <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
         data_oe_q   <= data_oe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // IF is stalled while MEM is about to be granted or already owns the bus.
   assign cpu.ram2_conflict_o = cpu.if_req_i &
                                (((state_q == ST_IDLE) & cpu.mem_req_i & ~mem_ack_q) |
                                 ((state_q != ST_IDLE) & (owner_q == OWN_MEM)));

   assign cpu.if_ack_o    = if_ack_q;
   assign cpu.if_rdata_o  = if_rdata_q;
   assign cpu.mem_ack_o   = mem_ack_q;
   assign cpu.mem_rdata_o = mem_rdata_q;
   assign ram_addr_o      = ram_addr_q;
   assign ram_data_o      = ram_data_q;
   assign ram_data_oe_o   = data_oe_q;
   assign ram_ce_n_o      = ce_n_q;
   assign ram_oe_n_o      = oe_n_q;
   assign ram_we_n_o      = we_n_q;
   assign dbg_state_o     = state_q;

endmodule
